// File: rtl/jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : jk_flip_flop
// Description : Bank of WIDTH independent clocked JK flip-flops sharing one
//               clock and one synchronous active-low reset. Each bit can hold,
//               set, clear or toggle. q_n is the combinational complement of q.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_flip_flop #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // Registered state of every cell.
  logic [WIDTH-1:0] r_q;

  // Next state per bit from the JK characteristic equation
  // q+ = (j & ~q) | (~k & q):
  //   j=0,k=0 -> q (hold)     j=1,k=0 -> 1 (set)
  //   j=0,k=1 -> 0 (clear)    j=1,k=1 -> ~q (toggle)
  // Being a pure bitwise expression, bits never interact and an unknown on
  // j or k propagates into the affected bit in simulation.
  logic [WIDTH-1:0] w_q_next;

  // Combinational next-state evaluation for all cells at once.
  always_comb begin
    w_q_next = (j & ~r_q) | (~k & r_q);
  end

  // State update; reset is sampled on the clock edge and overrides j/k.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q   = r_q;
  assign q_n = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_flip_flop
// Description : Self-checking bench for jk_flip_flop. Drives a 1-bit default
//               instance and a 4-bit instance (RESET_VAL=4'b1010) in lockstep
//               with a shared reset; expected values come from a bench-side
//               JK model and travel through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_flip_flop;

  logic       clk;
  logic       reset;
  logic       j1, k1;
  logic       q1, q1_n;
  logic [3:0] j4, k4;
  logic [3:0] q4, q4_n;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected-state model values and the scoreboard of pending expectations.
  logic       m1;
  logic [3:0] m4;
  logic [4:0] sb_q[$];

  jk_flip_flop dut1 (
    .clk   (clk),
    .reset (reset),
    .j     (j1),
    .k     (k1),
    .q     (q1),
    .q_n   (q1_n)
  );

  jk_flip_flop #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .j     (j4),
    .k     (k4),
    .q     (q4),
    .q_n   (q4_n)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference JK behaviour, written as a per-bit truth table.
  function automatic logic [3:0] jk_model(input logic [3:0] cur,
                                          input logic [3:0] jj,
                                          input logic [3:0] kk,
                                          input logic       rst_n,
                                          input logic [3:0] rv);
    logic [3:0] nxt;
    if (!rst_n) return rv;
    for (int b = 0; b < 4; b++) begin
      case ({jj[b], kk[b]})
        2'b00:   nxt[b] = cur[b];
        2'b10:   nxt[b] = 1'b1;
        2'b01:   nxt[b] = 1'b0;
        2'b11:   nxt[b] = ~cur[b];
        default: nxt[b] = 1'bx;
      endcase
    end
    return nxt;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock step: drive on the falling edge, push the expectation, then
  // pop and compare 1 unit after the rising edge.
  task automatic step(input string tag,
                      input logic jj1, input logic kk1,
                      input logic [3:0] jj4, input logic [3:0] kk4,
                      input logic rst_n);
    logic [4:0] e;
    logic [3:0] t1;
    @(negedge clk);
    j1 = jj1; k1 = kk1; j4 = jj4; k4 = kk4; reset = rst_n;
    t1 = jk_model({3'b000, m1}, {3'b000, jj1}, {3'b000, kk1}, rst_n, 4'b0000);
    m1 = t1[0];
    m4 = jk_model(m4, jj4, kk4, rst_n, 4'b1010);
    sb_q.push_back({m1, m4});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check1({tag, ".q1"},   q1,   e[4]);
      check1({tag, ".q1_n"}, q1_n, ~e[4]);
      check4({tag, ".q4"},   q4,   e[3:0]);
      check4({tag, ".q4_n"}, q4_n, ~e[3:0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    m1 = 1'bx; m4 = 4'bxxxx;

    // Reset with idle inputs, then with j=k=1 held: reset must win.
    step("rst_idle",   1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("rst_jk11",   1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    step("rst_jk11b",  1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);

    // Hold from reset value.
    step("hold0",      1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // Set on bit, mixed per-bit commands on the wide bank -> 1011.
    step("set_mixed",  1'b1, 1'b0, 4'b0011, 4'b0101, 1'b1);
    // Hold from q=1.
    step("hold1",      1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // Clear.
    step("clear",      1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    step("clear4",     1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);

    // Continuous toggle over 8 edges: 1,0,1,0,...
    for (int i = 0; i < 8; i++) begin
      step($sformatf("toggle%0d", i), 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    end

    // Toggle to q=1, then reset mid-sequence, then resume toggling.
    step("toggle_hi",  1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    step("mid_reset",  1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    step("resume",     1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    step("resume2",    1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);

    // A few random mixed-command steps.
    for (int i = 0; i < 12; i++) begin
      step($sformatf("rand%0d", i),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    end

    // Final sanity that the combinational complement still tracks between edges.
    @(negedge clk);
    check4("qn_between_edges", q4_n, ~m4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
- Clocked JK flip-flop bank.
- WIDTH independent JK cells share one clock and one synchronous active-low reset.
- Supports hold, set, clear and toggle per bit.
- Generic sequential primitive, used for counters, toggle registers and control flags.
- Default configuration is a single-bit JK flip-flop with a true output and a complementary output.

Parameters:
- WIDTH, 1, number of independent JK cells (bits); legal range 1..64.
- RESET_VAL, 0 (WIDTH bits), value loaded into q when reset is asserted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
- j  input  WIDTH  per-bit J (set) input.
- k  input  WIDTH  per-bit K (clear) input.
- q  output  WIDTH  registered state.
- q_n  output  WIDTH  bitwise complement of q, combinationally derived (always equals ~q).

Behaviour:
- Single clock domain. No asynchronous paths. Nothing changes between rising edges of clk.
- Reset:
  - Sampled only at the rising edge of clk.
  - If reset==0 at an edge, q <= RESET_VAL and q_n = ~RESET_VAL, regardless of j and k.
  - Reset has priority over all JK actions.
  - Deasserting reset takes effect at the next edge. The first edge with reset==1 performs a normal JK update.
- Power-up before the first reset edge: q is undefined (X in simulation). No initial value is required.
- Normal operation (reset==1), applied independently to each bit i at each rising edge:
  - j[i]=0, k[i]=0: hold, q[i] unchanged.
  - j[i]=1, k[i]=0: set, q[i] <= 1.
  - j[i]=0, k[i]=1: clear, q[i] <= 0.
  - j[i]=1, k[i]=1: toggle, q[i] <= ~q[i].
- Latency: one cycle. q reflects the j/k/reset values sampled at the most recent rising edge.
- Output timing: q is a pure register output with no combinational path from j/k. q_n is ~q with no extra cycle.
- Bit independence: bits never interact. Mixed commands in one cycle (e.g. bit0 set, bit1 toggle) are each applied to their own bit.
- Sustained toggle: continuous j=k=1 makes q alternate every cycle, a divide-by-2 of clk per bit.
- Mid-operation reset: reset==0 during a toggle sequence forces RESET_VAL at that edge. The toggle resumes from RESET_VAL once reset returns to 1.
- X handling: X on j or k while reset==1 produces X on the affected bit. Reset==0 clears any X.

Test Plan:
- Reset: clk period 10, j=k=0, hold reset=0 for one edge, then reset=1 -> q=0 and q_n=1 after the reset edge. With j=k=1 held during reset, q stays 0 for every reset edge.
- Hold: after reset, j=0,k=0 for one edge -> q stays 0. Also from q=1, one edge of hold -> q stays 1.
- Set then clear: j=1,k=0 for one edge -> q=1, q_n=0. Then j=0,k=1 for one edge -> q=0, q_n=1.
- Toggle: from q=0, apply j=1,k=1 for two edges -> q=1 after the first edge, q=0 after the second. Continuous toggle over 8 edges gives 1,0,1,0,1,0,1,0.
- Mid-toggle reset: during continuous toggle with q=1, drop reset to 0 for one edge -> q=0. Release reset with j=k=1 -> q=1 at the next edge.
- Multi-bit (WIDTH=4, RESET_VAL=4'b1010): after reset q=1010. Apply j=0011, k=0101 for one edge -> bit0 toggle 0->1, bit1 set 1->1, bit2 clear 0->0, bit3 hold 1 -> q=1011, q_n=0100.
